if_fetch: RTL and testbench

- Front-end fetch unit: the consumer of the pipeline control block's jump and hold outputs.
- Owns the PC and runs the instruction-bus request/acknowledge handshake.
- Buffers one returned instruction and presents it to the decode stage.
- Squashes in-flight fetches on jumps and freezes per the hold-level encoding from the control block.

---
 rtl/if_fetch.sv | 254 +++++++++++++++++++++++++
 tb/tb_if_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch front end
//
// Owns the program counter and runs the instruction-bus request/acknowledge
// handshake. It holds one returned instruction and presents it to decode. It
// responds to the pipeline control block's jump redirect and hold levels.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   jump_flag_i    redirect request from control (highest priority)
//   jump_addr_i    redirect target; bits [1:0] are dropped
//   hold_flag_i    hold level: 0 none, 1 PC, 2 IF, 3 ID (values >3 act as ID)
//   ibus_req_o     instruction bus request
//   ibus_addr_o    word-aligned fetch address (always the current PC)
//   ibus_ack_i     bus acknowledge, data valid in the same cycle
//   ibus_data_i    returned instruction word
//   inst_o         instruction presented to decode (NOP_INST when empty)
//   inst_addr_o    address of inst_o
//   inst_valid_o   inst_o is a real, unsquashed instruction
//   misalign_o     one-cycle pulse after a jump whose target had addr[1:0]!=0
//   fetch_cnt_o    number of instructions delivered to decode (wraps)
//
// States
//   state   | meaning
//   --------+----------------------------------------------------------------
//   S_IDLE  | one cycle after reset, no request
//   S_FETCH | request outstanding at r_pc, waiting for ack
//   S_STALL | instruction delivered under PC hold, waiting for hold release
//   S_HOLD  | ack taken under IF/ID hold, instruction parked in skid buffer
//   S_FLUSH | jump arrived with a request in flight; drain the stale ack
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_STALL = 3'd2,
        S_HOLD  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] r_skid_data;
    logic [31:0] r_skid_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;
    logic        r_inst_valid;
    logic        r_misalign;
    logic [31:0] r_fetch_cnt;

    logic [1:0]  w_hold_lvl;
    logic        w_hold_none;
    logic        w_hold_pc;
    logic        w_hold_if;
    logic [31:0] w_target;
    logic        w_req;

    // Control strobes from the next-state logic to the datapath.
    logic        w_squash;
    logic        w_pc_load_jump;
    logic        w_pc_load_latched;
    logic        w_pc_inc;
    logic        w_latch_target;
    logic        w_capture_skid;
    logic        w_deliver_bus;
    logic        w_deliver_skid;

    // Encodings above ID saturate to ID so an unexpected level freezes rather
    // than lets instructions through.
    assign w_hold_lvl  = (hold_flag_i > 3'b011) ? 2'b11 : hold_flag_i[1:0];
    assign w_hold_none = (w_hold_lvl == 2'b00);
    assign w_hold_pc   = (w_hold_lvl == 2'b01);
    assign w_hold_if   = w_hold_lvl[1];

    assign w_target    = {jump_addr_i[31:2], 2'b00};

    // The request is a pure function of state, so the address (r_pc) and the
    // request stay stable for as long as the FSM waits in S_FETCH/S_FLUSH.
    assign w_req       = (r_state == S_FETCH) || (r_state == S_FLUSH);

    assign ibus_req_o   = w_req;
    assign ibus_addr_o  = r_pc;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_valid_o = r_inst_valid;
    assign misalign_o   = r_misalign;
    assign fetch_cnt_o  = r_fetch_cnt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        w_squash          = 1'b0;
        w_pc_load_jump    = 1'b0;
        w_pc_load_latched = 1'b0;
        w_pc_inc          = 1'b0;
        w_latch_target    = 1'b0;
        w_capture_skid    = 1'b0;
        w_deliver_bus     = 1'b0;
        w_deliver_skid    = 1'b0;

        if (jump_flag_i) begin
            w_squash = 1'b1;
            if (w_req && !ibus_ack_i) begin
                // A request is in flight: it must complete at its original
                // address before the target can be fetched.
                w_latch_target = 1'b1;
                w_next_state   = S_FLUSH;
            end else begin
                // Nothing in flight, or the ack lands this cycle and is
                // dropped: the target can be requested immediately. Leaving
                // S_HOLD here is what empties the skid buffer.
                w_pc_load_jump = 1'b1;
                w_next_state   = S_FETCH;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_FETCH;
                end
                S_FETCH: begin
                    if (ibus_ack_i) begin
                        if (w_hold_if) begin
                            w_capture_skid = 1'b1;
                            w_next_state   = S_HOLD;
                        end else begin
                            w_deliver_bus = 1'b1;
                            if (w_hold_pc) begin
                                w_next_state = S_STALL;
                            end else begin
                                w_pc_inc = 1'b1;
                            end
                        end
                    end
                end
                S_STALL: begin
                    if (w_hold_none) begin
                        w_pc_inc     = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (!w_hold_if) begin
                        w_deliver_skid = 1'b1;
                        if (w_hold_pc) begin
                            w_next_state = S_STALL;
                        end else begin
                            w_pc_inc     = 1'b1;
                            w_next_state = S_FETCH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (ibus_ack_i) begin
                        w_pc_load_latched = 1'b1;
                        w_next_state      = S_FETCH;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: PC, jump target, skid buffer, decode outputs, counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_ADDR;
            r_target     <= RESET_ADDR;
            r_skid_data  <= NOP_INST;
            r_skid_addr  <= 32'h0000_0000;
            r_inst       <= NOP_INST;
            r_inst_addr  <= 32'h0000_0000;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_fetch_cnt  <= 32'h0000_0000;
        end else begin
            r_misalign <= jump_flag_i && (jump_addr_i[1:0] != 2'b00);

            // The PC is not advanced while parked in S_HOLD, so on release it
            // still equals the skid address and +4 gives the next fetch.
            if (w_pc_load_jump) begin
                r_pc <= w_target;
            end else if (w_pc_load_latched) begin
                r_pc <= r_target;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_latch_target) begin
                r_target <= w_target;
            end

            if (w_capture_skid) begin
                r_skid_data <= ibus_data_i;
                r_skid_addr <= r_pc;
            end

            if (w_squash) begin
                r_inst       <= NOP_INST;
                r_inst_valid <= 1'b0;
            end else if (w_deliver_bus) begin
                r_inst       <= ibus_data_i;
                r_inst_addr  <= r_pc;
                r_inst_valid <= 1'b1;
                r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            end else if (w_deliver_skid) begin
                r_inst       <= r_skid_data;
                r_inst_addr  <= r_skid_addr;
                r_inst_valid <= 1'b1;
                r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- bench for if_fetch. A transaction-level model (outstanding
// fetch, stale flag, parked instruction, waiting-for-release flag) predicts
// every output each cycle, with directed scenarios followed by random traffic.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_ack_i   (ibus_ack_i),
        .ibus_data_i  (ibus_data_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .misalign_o   (misalign_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_live  = 1'b0;
    bit          m_req   = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_skid_v = 1'b0;
    bit          m_stall = 1'b0;
    bit          m_boot  = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_mis   = 1'b0;
    logic [31:0] m_addr, m_tgt, m_skid_d, m_skid_a, m_inst, m_iaddr, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_deliver(input logic [31:0] d, input logic [31:0] a, input int lvl);
        m_inst  = d;
        m_iaddr = a;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
        if (lvl == 0) begin
            m_addr = a + 32'd4;
            m_req  = 1'b1;
        end else begin
            m_addr  = a;
            m_req   = 1'b0;
            m_stall = 1'b1;
        end
    endtask

    // One clock of the fetch unit's behaviour, from the inputs held over the edge.
    task automatic model_step();
        int          lvl;
        logic [31:0] tgt;
        lvl = (hold_flag_i > 3'd3) ? 3 : int'(hold_flag_i);
        tgt = {jump_addr_i[31:2], 2'b00};
        if (rst) begin
            m_live = 1'b1; m_req = 1'b0; m_stale = 1'b0; m_skid_v = 1'b0;
            m_stall = 1'b0; m_boot = 1'b1; m_addr = 32'h0; m_tgt = 32'h0;
            m_inst = NOP; m_iaddr = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else begin
            m_mis = jump_flag_i && (jump_addr_i[1:0] != 2'b00);
            if (jump_flag_i) begin
                m_inst   = NOP;
                m_valid  = 1'b0;
                m_skid_v = 1'b0;
                m_stall  = 1'b0;
                m_boot   = 1'b0;
                if (m_req && !ibus_ack_i) begin
                    m_stale = 1'b1;
                    m_tgt   = tgt;
                end else begin
                    m_stale = 1'b0;
                    m_req   = 1'b1;
                    m_addr  = tgt;
                end
            end else if (m_boot) begin
                m_boot = 1'b0;
                m_req  = 1'b1;
            end else if (m_req && ibus_ack_i) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = m_tgt;
                end else if (lvl >= 2) begin
                    m_skid_v = 1'b1;
                    m_skid_d = ibus_data_i;
                    m_skid_a = m_addr;
                    m_req    = 1'b0;
                end else begin
                    m_deliver(ibus_data_i, m_addr, lvl);
                end
            end else if (m_skid_v && lvl < 2) begin
                m_skid_v = 1'b0;
                m_deliver(m_skid_d, m_skid_a, lvl);
            end else if (m_stall && lvl == 0) begin
                m_stall = 1'b0;
                m_addr  = m_addr + 32'd4;
                m_req   = 1'b1;
            end
        end
    endtask

    // Advance one cycle, then compare every output against the model.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_live) begin
            check("ibus_req",   32'(ibus_req_o),   32'(m_req));
            check("ibus_addr",  ibus_addr_o,       m_addr);
            check("inst",       inst_o,            m_inst);
            check("inst_addr",  inst_addr_o,       m_iaddr);
            check("inst_valid", 32'(inst_valid_o), 32'(m_valid));
            check("misalign",   32'(misalign_o),   32'(m_mis));
            check("fetch_cnt",  fetch_cnt_o,       m_cnt);
        end
    endtask

    task automatic drive(input logic j, input logic [31:0] ja, input logic [2:0] h, input logic a);
        jump_flag_i = j;
        jump_addr_i = ja;
        hold_flag_i = h;
        ibus_ack_i  = a;
        ibus_data_i = ibus_addr_o ^ SALT;
        tick();
    endtask

    initial begin
        rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
        hold_flag_i = 3'b000; ibus_ack_i = 1'b0; ibus_data_i = 32'h0;
        tick();
        tick();
        check("rst_inst", inst_o, NOP);
        check("rst_cnt", fetch_cnt_o, 32'h0);
        check("rst_req", 32'(ibus_req_o), 32'h0);

        // 1: free-running fetch with ack every cycle
        rst = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t1_valid_c2", 32'(inst_valid_o), 32'h0);
        check("t1_req_c2", 32'(ibus_req_o), 32'h1);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t1_valid_c3", 32'(inst_valid_o), 32'h1);
        check("t1_inst0", inst_o, 32'hA5A5_0000);
        repeat (3) drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t1_cnt", fetch_cnt_o, 32'd4);
        check("t1_iaddr", inst_addr_o, 32'h0000_000C);
        check("t1_inst3", inst_o, 32'hA5A5_000C);

        // 2: ID hold on the ack for address 8, released after 3 cycles
        rst = 1'b1;
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        drive(1'b0, 32'h0, 3'b011, 1'b1);
        check("t2_frozen_addr", inst_addr_o, 32'h4);
        check("t2_req_drop", 32'(ibus_req_o), 32'h0);
        repeat (3) begin
            drive(1'b0, 32'h0, 3'b011, 1'b0);
            check("t2_hold_addr", inst_addr_o, 32'h4);
        end
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        check("t2_skid_addr", inst_addr_o, 32'h8);
        check("t2_skid_inst", inst_o, 32'hA5A5_0008);
        check("t2_cnt", fetch_cnt_o, 32'd3);
        check("t2_next_addr", ibus_addr_o, 32'hC);

        // 3: jump while the request to 0x10 is pending, ack 2 cycles late
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t3_pend_addr", ibus_addr_o, 32'h10);
        drive(1'b1, 32'h100, 3'b000, 1'b0);
        check("t3_flush_addr", ibus_addr_o, 32'h10);
        check("t3_flush_valid", 32'(inst_valid_o), 32'h0);
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        check("t3_flush_req", 32'(ibus_req_o), 32'h1);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t3_target_addr", ibus_addr_o, 32'h100);
        check("t3_discard_cnt", fetch_cnt_o, 32'd4);
        check("t3_discard_valid", 32'(inst_valid_o), 32'h0);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t3_deliver_addr", inst_addr_o, 32'h100);
        check("t3_deliver_cnt", fetch_cnt_o, 32'd5);

        // 4: misaligned jump target
        drive(1'b1, 32'h202, 3'b000, 1'b0);
        check("t4_mis_pulse", 32'(misalign_o), 32'h1);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t4_mis_clear", 32'(misalign_o), 32'h0);
        check("t4_aligned", ibus_addr_o, 32'h200);

        // 5: jump and ack together under ID hold
        drive(1'b1, 32'h300, 3'b011, 1'b1);
        check("t5_cnt", fetch_cnt_o, 32'd5);
        check("t5_req", 32'(ibus_req_o), 32'h1);
        check("t5_addr", ibus_addr_o, 32'h300);

        // 6: PC and counter wrap
        drive(1'b1, 32'hFFFF_FFFC, 3'b000, 1'b1);
        check("t6_pc_top", ibus_addr_o, 32'hFFFF_FFFC);
        ibus_ack_i = 1'b0;
        force dut.r_fetch_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_fetch_cnt;
        drive(1'b0, 32'h0, 3'b000, 1'b0);
        drive(1'b0, 32'h0, 3'b000, 1'b1);
        check("t6_cnt_wrap", fetch_cnt_o, 32'h0);
        check("t6_pc_wrap", ibus_addr_o, 32'h0);
        check("t6_iaddr", inst_addr_o, 32'hFFFF_FFFC);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            jump_flag_i = ($urandom_range(0, 9) == 0);
            jump_addr_i = ($urandom_range(0, 3) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            hold_flag_i = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            ibus_ack_i  = 1'($urandom_range(0, 1));
            ibus_data_i = 32'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
